// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encoding and round-robin pointer helper for stream_mux
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // wrap-around increment that stays correct for non-power-of-two channel counts
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant using a double-width masked priority search
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] gnt_o,
  output logic             gnt_valid_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;

  assign dbl  = {req_i, req_i};
  assign mask = ~(((2*N)'(1) << ptr_i) - (2*N)'(1));

  // lowest masked bit wins; the upper copy of the requests supplies the wrap-around
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && mask[j]) begin
        gnt_valid_o = 1'b1;
        gnt_o       = SEL_W'(j >= N ? j - N : j);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready mux, fixed or round-robin grant, registered output; STREAM_MUX_PKT_LOCK_EN adds packet lock
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_valid,
  input  logic [N-1:0]       i_last,
  output logic [N-1:0]       o_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_valid,
  output logic               o_last,
  output logic [SEL_W-1:0]   o_chan,
  input  logic               i_ready
);

  localparam int NP = 2**SEL_W;

  logic             load, acc;
  logic             sel_valid, gnt_valid, rr_valid;
  logic [SEL_W-1:0] sel_gnt, gnt, rr_gnt;
  logic [NP-1:0]    valid_x, last_x;
  logic [WIDTH-1:0] data_x [NP];
  logic             valid_q, valid_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d, rr_ptr_q, rr_ptr_d;

  // channels padded to a power of two so an out-of-range fixed select indexes safely
  always_comb begin
    valid_x = NP'(i_valid);
    last_x  = NP'(i_last);
    for (int k = 0; k < NP; k++) data_x[k] = '0;
    for (int k = 0; k < N; k++) data_x[k] = i_data[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(N)) u_arb (
    .req_i       (i_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (rr_gnt),
    .gnt_valid_o (rr_valid)
  );

  assign sel_gnt   = mode_e'(i_mode) == MODE_RR ? rr_gnt : i_sel;
  assign sel_valid = mode_e'(i_mode) == MODE_RR ? rr_valid : int'(i_sel) < N;
  assign load      = !valid_q || i_ready;
  assign acc       = i_rst_n && load && gnt_valid && valid_x[gnt];

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;

  assign gnt       = lock_q ? lock_chan_q : sel_gnt;
  assign gnt_valid = lock_q || sel_valid;

  // a non-last beat opens a packet on its channel; the last beat closes it
  always_comb begin
    lock_d      = acc ? !last_x[gnt] : lock_q;
    lock_chan_d = acc ? gnt : lock_chan_q;
  end

  // lock state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
    end
  end
`else
  assign gnt       = sel_gnt;
  assign gnt_valid = sel_valid;
`endif

  // only the granted channel sees ready, and only when the output can take a beat
  always_comb begin
    for (int k = 0; k < N; k++) o_ready[k] = i_rst_n && load && gnt_valid && gnt == SEL_W'(k);
  end

  // output stage loads on accept, empties on drain, otherwise holds
  always_comb begin
    valid_d  = acc ? 1'b1 : i_ready ? 1'b0 : valid_q;
    data_d   = acc ? data_x[gnt] : data_q;
    last_d   = acc ? last_x[gnt] : last_q;
    chan_d   = acc ? gnt : chan_q;
    rr_ptr_d = acc ? SEL_W'(rr_next(32'(gnt), N)) : rr_ptr_q;
  end

  // output and pointer registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: vector table, directed corner sequences and randomized model check for stream_mux (N=4 and N=3)
module tb_stream_mux;

`ifdef STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_mode, a_rdy, a_ov, a_ol;
  logic [1:0] a_sel, a_och;
  logic [31:0] a_data;
  logic [3:0] a_valid, a_last, a_ordy, a_seen;
  logic [7:0] a_od;
  logic b_mode, b_rdy, b_ov, b_ol;
  logic [1:0] b_sel, b_och;
  logic [23:0] b_data;
  logic [2:0] b_valid, b_last, b_ordy, b_seen;
  logic [7:0] b_od;

  stream_mux #(.WIDTH(8), .N(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(a_mode), .i_sel(a_sel), .i_data(a_data),
    .i_valid(a_valid), .i_last(a_last), .o_ready(a_ordy), .o_data(a_od),
    .o_valid(a_ov), .o_last(a_ol), .o_chan(a_och), .i_ready(a_rdy)
  );

  stream_mux #(.WIDTH(8), .N(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(b_mode), .i_sel(b_sel), .i_data(b_data),
    .i_valid(b_valid), .i_last(b_last), .o_ready(b_ordy), .o_data(b_od),
    .o_valid(b_ov), .o_last(b_ol), .o_chan(b_och), .i_ready(b_rdy)
  );

  typedef struct {
    logic v; logic [7:0] d; logic l; int ch; int ptr; logic lk; int lch;
  } ms_t;

  typedef struct {
    logic mode; logic [1:0] sel; logic [3:0] valid;
    logic [3:0] rdy_e; logic [7:0] d_e; logic [1:0] ch_e;
  } vec_t;

  ms_t ma, mb, ma_n, mb_n;
  vec_t tbl [12];
  int n_tests = 0, n_fail = 0;

  function automatic int grant(ms_t s, int n, logic mode, int sel, logic [3:0] valid);
    if (LOCK && s.lk) return s.lch;
    if (!mode) return sel < n ? sel : -1;
    for (int i = 0; i < n; i++) if (valid[(s.ptr + i) % n]) return (s.ptr + i) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(ms_t s, int n, logic mode, int sel, logic [3:0] valid, logic rdy, logic rn);
    int g = grant(s, n, mode, sel, valid);
    if (!rn || (s.v && !rdy) || g < 0) return 4'h0;
    return 4'(1 << g);
  endfunction

  function automatic ms_t step_m(ms_t s, int n, logic mode, int sel, logic [31:0] data,
                                 logic [3:0] valid, logic [3:0] last, logic rdy, logic rn);
    ms_t r = s;
    int g = grant(s, n, mode, sel, valid);
    if (!rn) begin
      r = '{default: 0};
      return r;
    end
    if ((!s.v || rdy) && g >= 0 && valid[g]) begin
      r.v = 1'b1; r.d = data[g*8 +: 8]; r.l = last[g]; r.ch = g; r.ptr = (g + 1) % n;
      if (LOCK) begin r.lk = !last[g]; r.lch = g; end
    end else if (rdy) r.v = 1'b0;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    #1;
    a_seen = a_ordy;
    b_seen = b_ordy;
    chk("a_ready_model", a_ordy, exp_rdy(ma, 4, a_mode, int'(a_sel), a_valid, a_rdy, rst_n));
    chk("b_ready_model", b_ordy, exp_rdy(mb, 3, b_mode, int'(b_sel), {1'b0, b_valid}, b_rdy, rst_n));
    ma_n = step_m(ma, 4, a_mode, int'(a_sel), a_data, a_valid, a_last, a_rdy, rst_n);
    mb_n = step_m(mb, 3, b_mode, int'(b_sel), {8'h0, b_data}, {1'b0, b_valid}, {1'b0, b_last}, b_rdy, rst_n);
    @(posedge clk);
    ma = ma_n;
    mb = mb_n;
    #1;
    chk("a_out_model", {a_ov, a_ol, a_och, a_od}, {ma.v, ma.l, 2'(ma.ch), ma.d});
    chk("b_out_model", {b_ov, b_ol, b_och, b_od}, {mb.v, mb.l, 2'(mb.ch), mb.d});
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_b [4];
    logic [1:0] exp_l [4];
    int beat;
    ma = '{default: 0}; mb = '{default: 0};
    rst_n = 1'b0;
    a_mode = 0; a_sel = 0; a_data = 0; a_valid = 0; a_last = 0; a_rdy = 0;
    b_mode = 0; b_sel = 0; b_data = 0; b_valid = 0; b_last = 0; b_rdy = 0;
    @(negedge clk);
    cyc();
    chk("reset_a", {a_ov, a_ol, a_och, a_od, a_ordy}, 32'h0);
    chk("reset_b", {b_ov, b_ol, b_och, b_od, b_ordy}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) tbl[i] = '{1'b0, 2'(i), 4'hF, 4'(1 << i), 8'(i + 1), 2'(i)};
    for (int i = 0; i < 8; i++) tbl[4+i] = '{1'b1, 2'd0, 4'hF, 4'(1 << (i % 4)), 8'(i % 4 + 1), 2'(i % 4)};
    a_data = 32'h04030201; a_last = 4'hF; a_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_mode = tbl[i].mode; a_sel = tbl[i].sel; a_valid = tbl[i].valid;
      cyc();
      chk("tbl_ready", a_seen, tbl[i].rdy_e);
      chk("tbl_out", {a_ov, a_och, a_od}, {1'b1, tbl[i].ch_e, tbl[i].d_e});
    end

    a_mode = 0; a_sel = 0; a_valid = 4'h1; a_data[7:0] = 8'h2A;
    cyc();
    chk("bp_load", {a_ov, a_od}, {1'b1, 8'h2A});
    a_rdy = 1'b0; a_data[7:0] = 8'h2B;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_ready_low", a_seen, 4'h0);
      chk("bp_hold", {a_ov, a_och, a_od}, {1'b1, 2'd0, 8'h2A});
    end
    a_rdy = 1'b1;
    cyc();
    chk("bp_release_ready", a_seen, 4'h1);
    chk("bp_no_bubble", {a_ov, a_od}, {1'b1, 8'h2B});

    b_rdy = 1'b1; b_last = 3'h7; b_data = 24'h332211;
    b_mode = 0; b_sel = 2'd1; b_valid = 3'b010;
    cyc();
    chk("n3_preload", {b_ov, b_och}, {1'b1, 2'd1});
    b_mode = 1; b_valid = 3'b101;
    exp_b = '{2'd2, 2'd0, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("n3_sparse_chan", {b_ov, b_och}, {1'b1, exp_b[i]});
    end
    b_mode = 0; b_sel = 2'd3; b_valid = 3'h7;
    cyc();
    chk("n3_sel_oob_ready", b_seen, 3'h0);
    chk("n3_sel_oob_valid", b_ov, 1'b0);

    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    a_mode = 1; a_rdy = 1; a_data[23:16] = 8'hC2; a_last = 4'b0100;
    exp_l = LOCK ? '{2'd1, 2'd1, 2'd1, 2'd2} : '{2'd1, 2'd2, 2'd1, 2'd2};
    beat = 0;
    for (int i = 0; i < 4; i++) begin
      a_data[15:8] = 8'(8'h10 + beat);
      a_last[1] = (beat == 2);
      a_valid = {1'b0, 1'b1, beat < 3, 1'b0};
      cyc();
      if (a_seen[1]) beat++;
      chk("pkt_chan", {a_ov, a_och}, {1'b1, exp_l[i]});
    end

    a_valid = 4'b0010; a_last = 4'h0; a_data[15:8] = 8'h55;
    cyc();
    chk("mid_pkt_load", {a_ov, a_och, a_od}, {1'b1, 2'd1, 8'h55});
    rst_n = 1'b0; a_valid = 4'hF;
    cyc();
    chk("mid_rst_ready", a_seen, 4'h0);
    chk("mid_rst_out", {a_ov, a_ol, a_och, a_od}, 32'h0);
    rst_n = 1'b1; a_last = 4'hF;
    cyc();
    chk("post_rst_chan0", {a_ov, a_och}, {1'b1, 2'd0});

    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 49) != 0;
      a_mode = 1'($urandom); a_sel = 2'($urandom); a_data = $urandom;
      a_valid = 4'($urandom); a_last = 4'($urandom); a_rdy = $urandom_range(0, 3) != 0;
      b_mode = 1'($urandom); b_sel = 2'($urandom); b_data = 24'($urandom);
      b_valid = 3'($urandom); b_last = 3'($urandom); b_rdy = $urandom_range(0, 3) != 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
